// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI flash slave model answering READ (0x03), JEDEC ID (0x9F) and
//   RESET (0xF0) from a small internal byte memory. All SPI pins are
//   oversampled in the clk_100mhz domain; nothing is clocked by sclk.
//
// Ports
//   clk_100mhz  system clock
//   nrst        asynchronous active-low reset
//   sclk        SPI clock (mode 0 or mode 3)
//   csn         chip select, active-low
//   mosi        serial data from master
//   rstn        flash reset pin, active-low (aborts transfer, clears busy)
//   wpn         write protect, unused (read-only device)
//   miso        serial data to master, 1 when idle
//   ld_we       memory load strobe
//   ld_addr     memory load address
//   ld_data     memory load data
//   busy        high during post-RESET recovery
//   cmd_valid   one-cycle pulse per captured opcode
//   last_cmd    most recently captured opcode
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for csn falling edge
// CMD     | shifting in 8-bit opcode
// ADDR    | shifting in 24-bit read address
// DATA    | shifting out memory bytes, address auto-increments
// ID      | shifting out the 24-bit JEDEC ID, then 1s
// WAIT_CS | RESET opcode seen, waiting for csn rise to arm recovery
// IGNORE  | frame rejected, miso held at 1 until csn rises

module spi_flash_responder #(
  parameter int          DEPTH     = 256,
  parameter int          RESET_CYC = 100,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
  parameter int          SYNC      = 2,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic          clk_100mhz,
  input  logic          nrst,
  input  logic          sclk,
  input  logic          csn,
  input  logic          mosi,
  input  logic          rstn,
  input  logic          wpn,
  output logic          miso,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          busy,
  output logic          cmd_valid,
  output logic [7:0]    last_cmd
);

  localparam int BCW = (RESET_CYC > 2) ? $clog2(RESET_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    DATA    = 3'd3,
    ID      = 3'd4,
    WAIT_CS = 3'd5,
    IGNORE  = 3'd6
  } state_t;

  state_t state, state_nxt;

  // synchronizers and edge detect
  logic [SYNC-1:0] sclk_sync, csn_sync, mosi_sync, rstn_sync;
  logic            sclk_d, csn_d;
  logic            sclk_s, csn_s, mosi_s, rstn_s;
  logic            sclk_rise, sclk_fall, csn_rise, csn_fall;

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      rstn_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC-2:0], sclk};
      csn_sync  <= {csn_sync[SYNC-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC-2:0], mosi};
      rstn_sync <= {rstn_sync[SYNC-2:0], rstn};
      sclk_d    <= sclk_sync[SYNC-1];
      csn_d     <= csn_sync[SYNC-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC-1];
  assign csn_s     = csn_sync[SYNC-1];
  assign mosi_s    = mosi_sync[SYNC-1];
  assign rstn_s    = rstn_sync[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ~csn_s & csn_d;

  // receive path
  logic [22:0] rx_sr;
  logic [23:0] rx_word;
  logic [4:0]  rx_cnt;
  logic        cmd_hit, addr_hit, busy_start;

  assign rx_word = {rx_sr, mosi_s};

  // transmit path
  logic [23:0]   tx_sr;
  logic [4:0]    tx_cnt;
  logic [AW-1:0] addr;
  logic          rd_req, rd_vld;
  logic [7:0]    mem_q;
  logic [7:0]    mem [DEPTH];
  logic          byte_done;

  logic [BCW-1:0] busy_cnt;

  logic unused_bits;
  assign unused_bits = wpn ^ rx_word[23];

  assign byte_done = (state == DATA) && sclk_fall && (tx_cnt == 5'd7);

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_hit    = 1'b0;
    addr_hit   = 1'b0;
    busy_start = 1'b0;
    if (!rstn_s) begin
      state_nxt = IDLE;
    end else if (csn_rise) begin
      state_nxt = IDLE;
      // reaching WAIT_CS guarantees exactly 8 bits were clocked
      if (state == WAIT_CS) busy_start = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (csn_fall) state_nxt = busy ? IGNORE : CMD;
        end
        CMD: begin
          if (sclk_rise && rx_cnt == 5'd7) begin
            cmd_hit = 1'b1;
            case (rx_word[7:0])
              8'h03:   state_nxt = ADDR;
              8'h9F:   state_nxt = ID;
              8'hF0:   state_nxt = WAIT_CS;
              default: state_nxt = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise && rx_cnt == 5'd23) begin
            addr_hit  = 1'b1;
            state_nxt = DATA;
          end
        end
        WAIT_CS: begin
          if (sclk_rise) state_nxt = IGNORE;
        end
        DATA, ID, IGNORE: state_nxt = state;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // opcode / address shifter
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      rx_sr     <= '0;
      rx_cnt    <= '0;
      cmd_valid <= 1'b0;
      last_cmd  <= '0;
    end else begin
      cmd_valid <= cmd_hit;
      if (cmd_hit) last_cmd <= rx_word[7:0];
      if (state == IDLE) begin
        rx_cnt <= '0;
      end else if (sclk_rise && (state == CMD || state == ADDR)) begin
        rx_sr  <= rx_word[22:0];
        rx_cnt <= (cmd_hit || addr_hit) ? 5'd0 : rx_cnt + 5'd1;
      end
    end
  end

  // memory: load port and 1-clk synchronous read; same-cycle
  // read/write of one address returns the old byte
  always_ff @(posedge clk_100mhz) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    mem_q <= mem[addr];
  end

  // address and prefetch: rd_req marks that addr has just changed,
  // rd_vld marks that mem_q now holds the byte for it
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      addr   <= '0;
      rd_req <= 1'b0;
      rd_vld <= 1'b0;
    end else begin
      rd_req <= addr_hit | byte_done;
      rd_vld <= rd_req;
      if (addr_hit)       addr <= rx_word[AW-1:0];
      else if (byte_done) addr <= addr + AW'(1);
    end
  end

  // output shifter: DATA uses the top byte of tx_sr, ID the full 24 bits
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      tx_sr  <= '0;
      tx_cnt <= '0;
      miso   <= 1'b1;
    end else begin
      if (cmd_hit && rx_word[7:0] == 8'h9F) begin
        tx_sr  <= JEDEC_ID;
        tx_cnt <= '0;
      end else if (rd_vld && state == DATA) begin
        tx_sr  <= {mem_q, 16'h0000};
        tx_cnt <= '0;
      end else if (sclk_fall && (state == DATA || state == ID)) begin
        if (state == DATA || tx_cnt != 5'd24) begin
          tx_sr  <= {tx_sr[22:0], 1'b0};
          tx_cnt <= byte_done ? 5'd0 : tx_cnt + 5'd1;
        end
      end

      if (state_nxt != DATA && state_nxt != ID) begin
        miso <= 1'b1;
      end else if (sclk_fall) begin
        if (state == ID && tx_cnt == 5'd24) miso <= 1'b1;
        else                                miso <= tx_sr[23];
      end
    end
  end

  // post-RESET recovery timer
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      busy     <= 1'b0;
      busy_cnt <= '0;
    end else if (!rstn_s) begin
      busy     <= 1'b0;
      busy_cnt <= '0;
    end else if (busy_start) begin
      busy     <= 1'b1;
      busy_cnt <= BCW'(RESET_CYC - 1);
    end else if (busy) begin
      if (busy_cnt == '0) busy <= 1'b0;
      else                busy_cnt <= busy_cnt - BCW'(1);
    end
  end

endmodule
